// File: rtl/audio_mixer_nch.sv
// audio_mixer_nch: NCH-channel stereo PSG/beeper mixer. After each sample
// strobe the channels are summed one per cycle into left/right PCM totals,
// each of which feeds a first-order sigma-delta 1-bit DAC.
//
// Strobe semantics: sample_stb is a single-cycle request with no back-pressure.
// It is taken only in IDLE; a strobe seen while busy (ACC or DONE) is dropped
// and latches the sticky overrun flag. pcm_valid pulses for exactly one cycle,
// and in that same cycle pcm_left/pcm_right already carry the new mix.
module audio_mixer_nch #(
    parameter int NCH        = 3,
    parameter int W          = 8,
    parameter     BEEP_LEVEL = 8'd64,
    // Wide enough for NCH full-scale channels plus two beeper terms, so the
    // accumulation can never wrap.
    parameter int ACCW       = W + $clog2(NCH + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_stb,
    input  logic [NCH*W-1:0]  ch_data,
    input  logic              ear,
    input  logic              mic,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [4:0]        cfg_data,
    output logic              busy,
    output logic              overrun,
    output logic [ACCW-1:0]   pcm_left,
    output logic [ACCW-1:0]   pcm_right,
    output logic              pcm_valid,
    output logic              audio_out_left,
    output logic              audio_out_right
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;

    // Live configuration, written by the cfg port at any time.
    logic [NCH-1:0]      r_pan_l;
    logic [NCH-1:0]      r_pan_r;
    logic [NCH*3-1:0]    r_att;

    // Snapshot taken at the strobe so mid-mix config writes cannot disturb it.
    logic [NCH*W-1:0]    r_sh_data;
    logic [NCH-1:0]      r_sh_pan_l;
    logic [NCH-1:0]      r_sh_pan_r;
    logic [NCH*3-1:0]    r_sh_att;

    logic [IW-1:0]       r_idx;
    logic [ACCW-1:0]     r_acc_l;
    logic [ACCW-1:0]     r_acc_r;
    logic [ACCW-1:0]     r_pcm_l;
    logic [ACCW-1:0]     r_pcm_r;
    logic                r_pcm_valid;
    logic                r_busy;
    logic                r_overrun;
    logic [ACCW:0]       r_err_l;
    logic [ACCW:0]       r_err_r;

    logic                w_last;
    logic [ACCW-1:0]     w_term;
    logic                w_pan_l;
    logic                w_pan_r;
    logic [ACCW-1:0]     w_beep;
    logic [ACCW-1:0]     w_acc_l_next;
    logic [ACCW-1:0]     w_acc_r_next;

    assign w_last       = (r_idx == IW'(NCH - 1));
    assign w_beep       = (ear ? ACCW'(BEEP_LEVEL) : '0) + (mic ? ACCW'(BEEP_LEVEL) : '0);
    assign w_acc_l_next = r_acc_l + (w_pan_l ? w_term : '0);
    assign w_acc_r_next = r_acc_r + (w_pan_r ? w_term : '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic: IDLE -> ACC on strobe, ACC for NCH cycles, one DONE cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (sample_stb) w_state_next = S_ACC;
            S_ACC:   if (w_last)     w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Select the current channel's attenuated sample and pan bits from the shadow.
    always_comb begin
        w_term  = '0;
        w_pan_l = 1'b0;
        w_pan_r = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (r_idx == IW'(i)) begin
                // A shift of W or more naturally yields zero.
                w_term  = ACCW'(r_sh_data[i*W +: W] >> r_sh_att[i*3 +: 3]);
                w_pan_l = r_sh_pan_l[i];
                w_pan_r = r_sh_pan_r[i];
            end
        end
    end

    // Configuration registers; writes to channels >= NCH fall through the loop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pan_l <= '1;
            r_pan_r <= '1;
            r_att   <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_ch == 3'(i)) begin
                    r_pan_l[i]       <= cfg_data[4];
                    r_pan_r[i]       <= cfg_data[3];
                    r_att[i*3 +: 3]  <= cfg_data[2:0];
                end
            end
        end
    end

    // Mix datapath: snapshot on strobe, accumulate in ACC, publish on the last channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh_data   <= '0;
            r_sh_pan_l  <= '0;
            r_sh_pan_r  <= '0;
            r_sh_att    <= '0;
            r_idx       <= '0;
            r_acc_l     <= '0;
            r_acc_r     <= '0;
            r_pcm_l     <= '0;
            r_pcm_r     <= '0;
            r_pcm_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_pcm_valid <= 1'b0;
            if (sample_stb && (r_state != S_IDLE)) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (sample_stb) begin
                        r_sh_data  <= ch_data;
                        r_sh_pan_l <= r_pan_l;
                        r_sh_pan_r <= r_pan_r;
                        r_sh_att   <= r_att;
                        r_acc_l    <= w_beep;
                        r_acc_r    <= w_beep;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_ACC: begin
                    r_acc_l <= w_acc_l_next;
                    r_acc_r <= w_acc_r_next;
                    if (w_last) begin
                        r_pcm_l     <= w_acc_l_next;
                        r_pcm_r     <= w_acc_r_next;
                        r_pcm_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: r_busy <= 1'b0;
                default: ;
            endcase
        end
    end

    // Sigma-delta DACs: the carry out of the error accumulator is the output bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_l <= '0;
            r_err_r <= '0;
        end else begin
            r_err_l <= {1'b0, r_err_l[ACCW-1:0]} + {1'b0, r_pcm_l};
            r_err_r <= {1'b0, r_err_r[ACCW-1:0]} + {1'b0, r_pcm_r};
        end
    end

    assign busy            = r_busy;
    assign overrun         = r_overrun;
    assign pcm_left        = r_pcm_l;
    assign pcm_right       = r_pcm_r;
    assign pcm_valid       = r_pcm_valid;
    assign audio_out_left  = r_err_l[ACCW];
    assign audio_out_right = r_err_r[ACCW];

endmodule
